// File: rtl/acc_reduce_unit.sv
// ---------------------------------------------------------------------------
// acc_reduce_unit
//
// Shared-accumulator reduction unit. N_CORE cores post add-requests to N_ACC
// 32-bit accumulators. Each accumulator owns a fixed-latency adder pipeline
// with result bypass, a stamp-ordered arbiter and a direct write/clear path.
//
// Handshake: a request on (core c, acc a) transfers on a rising edge where
// req_valid[c][a] && req_ready[c][a]. Ready goes only to the arbitration winner
// of that accumulator and only when the accumulator can accept this cycle.
// Ready depends on the core's own valid solely through winner selection.
//
// Configuration macro: ACC_REDUCE_FLOAT_EN
//   defined   -> fp32 add through the fadd_core IP (LATENCY must match it)
//   undefined -> 32-bit wrap-around integer add through a LATENCY-stage pipe
//
// Ports
//   clk        in   clock
//   reset      in   synchronous, active-high
//   req_valid  in   [N_CORE][N_ACC]           core c requests add into acc a
//   req_ready  out  [N_CORE][N_ACC]           grant
//   req_data   in   [N_CORE][N_ACC] x 32      addend
//   req_stamp  in   [N_CORE][N_ACC] x GC_WIDTH signed ordering stamp
//   gd_sign    in   0: smallest stamp wins, 1: largest stamp wins
//   wr_en      in   direct write strobe
//   wr_idx     in   target accumulator (out-of-range ignored)
//   wr_data    in   write value
//   acc_rdata  out  [N_ACC] x 32              registered accumulator values
//   acc_idle   out  every accumulator has count <= 1
//   no_req     out  no req_valid asserted anywhere
// ---------------------------------------------------------------------------
module acc_reduce_unit #(
    parameter int N_CORE   = 4,
    parameter int N_ACC    = 3,
    parameter int LATENCY  = 6,
    parameter int GC_WIDTH = 16,
    localparam int IW      = (N_ACC > 1) ? $clog2(N_ACC) : 1
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [N_CORE-1:0][N_ACC-1:0]             req_valid,
    output logic [N_CORE-1:0][N_ACC-1:0]             req_ready,
    input  logic [N_CORE-1:0][N_ACC-1:0][31:0]       req_data,
    input  logic [N_CORE-1:0][N_ACC-1:0][GC_WIDTH-1:0] req_stamp,
    input  logic                                     gd_sign,
    input  logic                                     wr_en,
    input  logic [IW-1:0]                            wr_idx,
    input  logic [31:0]                              wr_data,
    output logic [N_ACC-1:0][31:0]                   acc_rdata,
    output logic                                     acc_idle,
    output logic                                     no_req
);

    localparam int CW = $clog2(LATENCY + 1);
    localparam int SW = (N_CORE > 1) ? $clog2(N_CORE) : 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(LATENCY);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [N_ACC-1:0] w_cnt_le1;

    assign no_req   = ~(|req_valid);
    assign acc_idle = &w_cnt_le1;

    for (genvar a = 0; a < N_ACC; a++) begin : g_acc
        logic [CW-1:0]                r_cnt;
        logic [31:0]                  r_acc;
        logic                         w_found;
        logic [SW-1:0]                w_win;
        logic signed [GC_WIDTH-1:0]   w_best;
        logic [31:0]                  w_win_data;
        logic                         w_wr_hit;
        logic                         w_accept_ok;
        logic                         w_accept;
        logic [31:0]                  w_operand;
        logic [31:0]                  w_result;

        // Strict comparison keeps the earlier (lower-index) core on equal stamps.
        always_comb begin
            w_found    = 1'b0;
            w_win      = '0;
            w_best     = '0;
            w_win_data = '0;
            for (int c = 0; c < N_CORE; c++) begin
                if (req_valid[c][a] &&
                    (!w_found ||
                     (gd_sign ? ($signed(req_stamp[c][a]) > w_best)
                              : ($signed(req_stamp[c][a]) < w_best)))) begin
                    w_found    = 1'b1;
                    w_win      = SW'(c);
                    w_best     = $signed(req_stamp[c][a]);
                    w_win_data = req_data[c][a];
                end
            end
        end

        assign w_wr_hit    = wr_en && (32'(wr_idx) == 32'(a));
        assign w_accept_ok = (r_cnt <= CNT_ONE) && !w_wr_hit;
        assign w_accept    = w_accept_ok && w_found;

        for (genvar c = 0; c < N_CORE; c++) begin : g_rdy
            assign req_ready[c][a] = w_accept_ok && w_found && (w_win == SW'(c));
        end

        // Bypass: when the previous result is landing this cycle, chain from it.
        assign w_operand = (r_cnt == CNT_ONE) ? w_result : r_acc;

`ifdef ACC_REDUCE_FLOAT_EN
        fadd_core #(
            .LATENCY (LATENCY)
        ) u_fadd (
            .clk   (clk),
            .i_a   (w_operand),
            .i_b   (w_win_data),
            .o_sum (w_result)
        );
`else
        logic [LATENCY-1:0][31:0] r_pipe;
        logic [31:0]              w_sum;

        assign w_sum    = w_operand + w_win_data;
        assign w_result = r_pipe[LATENCY-1];

        // The pipe shifts every cycle; r_cnt decides which slot is meaningful.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_pipe <= '0;
            end else begin
                r_pipe <= {r_pipe[LATENCY-2:0], w_sum};
            end
        end
`endif

        // A direct write clears the count, so an in-flight result never lands.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_wr_hit) begin
                r_acc <= wr_data;
                r_cnt <= '0;
            end else begin
                if (r_cnt == CNT_ONE) begin
                    r_acc <= w_result;
                end
                if (w_accept) begin
                    r_cnt <= CNT_FULL;
                end else if (r_cnt != '0) begin
                    r_cnt <= r_cnt - CNT_ONE;
                end
            end
        end

        assign acc_rdata[a] = r_acc;
        assign w_cnt_le1[a] = (r_cnt <= CNT_ONE);
    end

endmodule

// File: tb/tb_acc_reduce_unit.sv
module tb_acc_reduce_unit;

    localparam int NC  = 4;
    localparam int NA  = 3;
    localparam int LAT = 6;
    localparam int GW  = 16;

    logic                          clk;
    logic                          reset;
    logic [NC-1:0][NA-1:0]         req_valid;
    logic [NC-1:0][NA-1:0]         req_ready;
    logic [NC-1:0][NA-1:0][31:0]   req_data;
    logic [NC-1:0][NA-1:0][GW-1:0] req_stamp;
    logic                          gd_sign;
    logic                          wr_en;
    logic [1:0]                    wr_idx;
    logic [31:0]                   wr_data;
    logic [NA-1:0][31:0]           acc_rdata;
    logic                          acc_idle;
    logic                          no_req;

    acc_reduce_unit #(
        .N_CORE   (NC),
        .N_ACC    (NA),
        .LATENCY  (LAT),
        .GC_WIDTH (GW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_stamp (req_stamp),
        .gd_sign   (gd_sign),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .acc_rdata (acc_rdata),
        .acc_idle  (acc_idle),
        .no_req    (no_req)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Each accumulator: committed value, plus at most one pending add that
    // lands at the end of cycle m_land (accept cycle + LAT).
    logic [31:0] m_acc  [NA];
    logic [31:0] m_pval [NA];
    bit          m_pend [NA];
    int          m_land [NA];
    int          m_grants [NA];
    int          cyc;

    int n_checks;
    int n_err;

    logic [31:0] exp_q[$];
    bit          ord_on;
    int          ord_acc;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int a = 0; a < NA; a++) begin
            m_acc[a]  = '0;
            m_pval[a] = '0;
            m_pend[a] = 1'b0;
            m_land[a] = 0;
        end
    endtask

    // One clock cycle: inputs were set after the previous negedge.
    task automatic step();
        logic [NC-1:0][NA-1:0] exp_rdy;
        bit                    idle_exp;
        #1;
        exp_rdy  = '0;
        idle_exp = 1'b1;
        for (int a = 0; a < NA; a++) begin
            int                   w;
            logic signed [GW-1:0] b;
            bit                   free;
            w    = -1;
            b    = '0;
            free = !m_pend[a] || (cyc == m_land[a]);
            if (!free) idle_exp = 1'b0;
            for (int c = 0; c < NC; c++) begin
                if (req_valid[c][a]) begin
                    if (w < 0 || (gd_sign ? ($signed(req_stamp[c][a]) > b)
                                          : ($signed(req_stamp[c][a]) < b))) begin
                        w = c;
                        b = $signed(req_stamp[c][a]);
                    end
                end
            end
            if (free && !(wr_en && (32'(wr_idx) == a)) && w >= 0) exp_rdy[w][a] = 1'b1;
        end
        check("ready", 32'(req_ready), 32'(exp_rdy));
        for (int a = 0; a < NA; a++) begin
            int ones;
            ones = 0;
            for (int c = 0; c < NC; c++) ones += int'(req_ready[c][a]);
            check("ready_onehot", 32'(ones <= 1), 32'd1);
            check("acc_rdata", acc_rdata[a], m_acc[a]);
        end
        check("acc_idle", 32'(acc_idle), 32'(idle_exp));
        check("no_req", 32'(no_req), 32'(req_valid == '0));
        if (ord_on) begin
            for (int c = 0; c < NC; c++) begin
                if (req_ready[c][ord_acc] && req_valid[c][ord_acc]) begin
                    if (exp_q.size() == 0) check("order_extra", 32'(c), 32'hFFFF_FFFF);
                    else check("order", 32'(c), exp_q.pop_front());
                end
            end
        end
        // advance the model across the edge
        for (int a = 0; a < NA; a++) begin
            if (reset) begin
                m_acc[a]  = '0;
                m_pend[a] = 1'b0;
            end else if (wr_en && (32'(wr_idx) == a)) begin
                m_acc[a]  = wr_data;
                m_pend[a] = 1'b0;
            end else begin
                if (m_pend[a] && cyc == m_land[a]) begin
                    m_acc[a]  = m_pval[a];
                    m_pend[a] = 1'b0;
                end
                for (int c = 0; c < NC; c++) begin
                    if (exp_rdy[c][a]) begin
                        m_pval[a] = m_acc[a] + req_data[c][a];
                        m_pend[a] = 1'b1;
                        m_land[a] = cyc + LAT;
                        m_grants[a]++;
                    end
                end
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        // a granted core drops its request
        for (int c = 0; c < NC; c++)
            for (int a = 0; a < NA; a++)
                if (exp_rdy[c][a]) req_valid[c][a] = 1'b0;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic post_req(input int c, input int a, input logic [31:0] d, input int st);
        req_valid[c][a] = 1'b1;
        req_data[c][a]  = d;
        req_stamp[c][a] = GW'(st);
    endtask

    // waits (bounded) until the request on (c,a) has been taken
    task automatic wait_taken(input int c, input int a);
        int n;
        n = 0;
        while (req_valid[c][a] && n < 40) begin
            step();
            n++;
        end
        check("grant_timeout", 32'(req_valid[c][a]), 32'd0);
    endtask

    task automatic run_order(input logic gs, input logic [31:0] base);
        int n;
        gd_sign = gs;
        post_req(0, 1, base + 1, 7);
        post_req(1, 1, base + 2, 3);
        post_req(2, 1, base + 3, 9);
        post_req(3, 1, base + 4, 3);
        ord_on  = 1'b1;
        ord_acc = 1;
        n = 0;
        while (req_valid[3:0] != '0 && n < 60) begin
            step();
            n++;
        end
        ord_on = 1'b0;
        check("order_left", 32'(exp_q.size()), 32'd0);
        idle_steps(LAT + 2);
    endtask

    initial begin
        logic [31:0] acc1_prev;
        int          tg;
        int          n;
        n_checks  = 0;
        n_err     = 0;
        cyc       = 0;
        ord_on    = 1'b0;
        ord_acc   = 0;
        req_valid = '0;
        req_data  = '0;
        req_stamp = '0;
        gd_sign   = 1'b0;
        wr_en     = 1'b0;
        wr_idx    = '0;
        wr_data   = '0;
        for (int a = 0; a < NA; a++) m_grants[a] = 0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // reset / idle state
        #1;
        check("rst_acc0", acc_rdata[0], 32'd0);
        check("rst_idle", 32'(acc_idle), 32'd1);
        check("rst_noreq", 32'(no_req), 32'd1);
        idle_steps(2);

        // single add: acc0 = 5, visible LAT+1 cycles after accept
        post_req(0, 0, 32'd5, 0);
        wait_taken(0, 0);
        tg = cyc - 1;
        while (cyc < tg + LAT) step();
        #1 check("acc0_before", acc_rdata[0], 32'd0);
        step();
        #1 check("acc0_five", acc_rdata[0], 32'd5);
        idle_steps(2);

        // stamp ordering, smallest first: cores 1,3,0,2
        exp_q.push_back(1); exp_q.push_back(3); exp_q.push_back(0); exp_q.push_back(2);
        run_order(1'b0, 32'd10);
        check("acc1_sum_min", acc_rdata[1], 32'd50);
        // largest first: cores 2,0,1,3
        exp_q.push_back(2); exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
        run_order(1'b1, 32'd100);
        check("acc1_sum_max", acc_rdata[1], 32'd460);
        gd_sign = 1'b0;

        // back-to-back stream of ten +1 into acc2 via bypass
        m_grants[2] = 0;
        n = 0;
        post_req(0, 2, 32'd1, 0);
        while (m_grants[2] < 10 && n < 100) begin
            step();
            n++;
            if (!req_valid[0][2] && m_grants[2] < 10) post_req(0, 2, 32'd1, 0);
        end
        req_valid[0][2] = 1'b0;
        idle_steps(LAT + 2);
        check("stream_acc2", acc_rdata[2], 32'd10);

        // direct write discards in-flight add
        post_req(0, 0, 32'd100, 0);
        wait_taken(0, 0);
        idle_steps(2);
        wr_en = 1'b1; wr_idx = 2'd0; wr_data = 32'd42;
        step();
        wr_en = 1'b0;
        idle_steps(LAT + 4);
        check("wr_acc0", acc_rdata[0], 32'd42);
        wr_en = 1'b1; wr_idx = 2'd3; wr_data = 32'd77;
        step();
        wr_en = 1'b0;
        idle_steps(2);
        check("wr_oor_acc0", acc_rdata[0], 32'd42);
        check("wr_oor_acc2", acc_rdata[2], 32'd10);

        // reset while an add is in flight (count = 3)
        acc1_prev = m_acc[1];
        post_req(2, 1, 32'hFFFF_FFFF, 0);
        wait_taken(2, 1);
        idle_steps(3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle_steps(LAT + 4);
        check("rst_mid_acc1", acc_rdata[1], 32'd0);
        check("rst_mid_changed", 32'(acc1_prev != 32'd0), 32'd1);

        // wrap-around: 0xFFFFFFFF + 2 = 1
        post_req(0, 1, 32'hFFFF_FFFF, 0);
        wait_taken(0, 1);
        post_req(0, 1, 32'd2, 0);
        wait_taken(0, 1);
        idle_steps(LAT + 2);
        check("wrap_acc1", acc_rdata[1], 32'd1);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < NC; c++)
                for (int a = 0; a < NA; a++)
                    if (!req_valid[c][a] && $urandom_range(0, 3) == 0)
                        post_req(c, a, $urandom, int'($urandom_range(0, 8)) - 4);
            if ($urandom_range(0, 7) == 0) gd_sign = ~gd_sign;
            wr_en   = ($urandom_range(0, 15) == 0);
            wr_idx  = 2'($urandom_range(0, 3));
            wr_data = $urandom;
            reset   = ($urandom_range(0, 149) == 0);
            step();
        end
        req_valid = '0;
        wr_en     = 1'b0;
        reset     = 1'b0;
        idle_steps(LAT + 2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
